// File: rtl/tick_divider.sv
// tick_divider: a bank of CHANNELS independent programmable tick generators.
// Each channel counts 0..P and emits a registered one-cycle tick on wrap,
// giving a tick every P+1 enabled cycles. P==0 parks the channel.
// Optional build macro: TICK_DIVIDER_ONESHOT_EN adds a per-channel one-shot
// mode (fire once, then stay stopped until restart or reset re-arms).
module tick_divider #(
  parameter int               WIDTH          = 16,
  parameter int               CHANNELS       = 4,
  parameter logic [WIDTH-1:0] DEFAULT_PERIOD = {WIDTH{1'b1}},
  localparam int              SEL_W          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                period_wr,
  input  logic [SEL_W-1:0]    period_sel,
  input  logic [WIDTH-1:0]    period_in,
  input  logic [CHANNELS-1:0] restart,
`ifdef TICK_DIVIDER_ONESHOT_EN
  input  logic [CHANNELS-1:0] oneshot,
`endif
  output logic [CHANNELS-1:0] tick
);

  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

  logic [WIDTH-1:0]    c_q [CHANNELS];
  logic [WIDTH-1:0]    c_d [CHANNELS];
  logic [WIDTH-1:0]    p_q [CHANNELS];
  logic [WIDTH-1:0]    p_d [CHANNELS];
  logic [CHANNELS-1:0] tick_q;
  logic [CHANNELS-1:0] tick_d;
`ifdef TICK_DIVIDER_ONESHOT_EN
  logic [CHANNELS-1:0] armed_q;
  logic [CHANNELS-1:0] armed_d;
`endif

  // Next-state for every channel: period write, restart, enable gating, wrap.
  // Comparisons use the period held before this edge so a write only takes
  // effect from the following cycle; a counter found above its (shrunk)
  // period is cleared without ticking, so it never runs past P or wraps.
  always_comb begin
    c_d    = c_q;
    p_d    = p_q;
    tick_d = {CHANNELS{1'b0}};
`ifdef TICK_DIVIDER_ONESHOT_EN
    armed_d = armed_q;
`endif
    for (int i = 0; i < CHANNELS; i++) begin
      // A select that matches no channel index simply writes nothing.
      if (period_wr && (int'(period_sel) == i)) begin
        p_d[i] = period_in;
      end else begin
        p_d[i] = p_q[i];
      end

      if (restart[i]) begin
        c_d[i] = CNT_ZERO;
`ifdef TICK_DIVIDER_ONESHOT_EN
        armed_d[i] = 1'b1;
`endif
      end else if (!en) begin
        c_d[i] = c_q[i];
      end else if (p_q[i] == CNT_ZERO) begin
        c_d[i] = CNT_ZERO;
`ifdef TICK_DIVIDER_ONESHOT_EN
      end else if (!armed_q[i]) begin
        c_d[i] = CNT_ZERO;
`endif
      end else if (c_q[i] == p_q[i]) begin
        c_d[i]    = CNT_ZERO;
        tick_d[i] = 1'b1;
`ifdef TICK_DIVIDER_ONESHOT_EN
        if (oneshot[i]) begin
          armed_d[i] = 1'b0;
        end else begin
          armed_d[i] = armed_q[i];
        end
`endif
      end else if (c_q[i] > p_q[i]) begin
        c_d[i] = CNT_ZERO;
      end else begin
        c_d[i] = c_q[i] + CNT_ONE;
      end
    end
  end

  // State registers with synchronous reset that overrides all other inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        c_q[i] <= CNT_ZERO;
        p_q[i] <= DEFAULT_PERIOD;
      end
      tick_q <= {CHANNELS{1'b0}};
`ifdef TICK_DIVIDER_ONESHOT_EN
      armed_q <= {CHANNELS{1'b1}};
`endif
    end else begin
      c_q    <= c_d;
      p_q    <= p_d;
      tick_q <= tick_d;
`ifdef TICK_DIVIDER_ONESHOT_EN
      armed_q <= armed_d;
`endif
    end
  end

  assign tick = tick_q;

endmodule

// File: tb/tb_tick_divider.sv
// tb_tick_divider: self-checking bench for tick_divider (WIDTH=8, CHANNELS=4,
// DEFAULT_PERIOD=3). Directed scenarios plus randomized traffic compared
// against an arithmetic reference model. Honors TICK_DIVIDER_ONESHOT_EN.
module tb_tick_divider;

  localparam int CH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       period_wr = 1'b0;
  logic [1:0] period_sel = 2'd0;
  logic [7:0] period_in = 8'd0;
  logic [3:0] restart = 4'h0;
`ifdef TICK_DIVIDER_ONESHOT_EN
  logic [3:0] oneshot = 4'h0;
`endif
  logic [3:0] tick;

  int checks = 0;
  int failures = 0;

  // Reference model state: counter and period as plain integers.
  int         m_c [CH];
  int         m_p [CH];
  bit         m_armed [CH];
  logic [3:0] m_tick;

  tick_divider #(
    .WIDTH(8),
    .CHANNELS(4),
    .DEFAULT_PERIOD(8'd3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .en(en),
    .period_wr(period_wr),
    .period_sel(period_sel),
    .period_in(period_in),
    .restart(restart),
`ifdef TICK_DIVIDER_ONESHOT_EN
    .oneshot(oneshot),
`endif
    .tick(tick)
  );

  always #5 clk = ~clk;

  // Advance the model by one edge using the inputs currently driven.
  task automatic model_step();
    int np;
    logic [3:0] os;
`ifdef TICK_DIVIDER_ONESHOT_EN
    os = oneshot;
`else
    os = 4'h0;
`endif
    if (reset) begin
      for (int i = 0; i < CH; i++) begin
        m_c[i] = 0;
        m_p[i] = 3;
        m_armed[i] = 1'b1;
      end
      m_tick = 4'h0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        np = (period_wr && int'(period_sel) == i) ? int'(period_in) : m_p[i];
        m_tick[i] = 1'b0;
        if (restart[i]) begin
          m_c[i] = 0;
          m_armed[i] = 1'b1;
        end else if (en) begin
          if (m_p[i] == 0 || !m_armed[i] || m_c[i] > m_p[i]) begin
            m_c[i] = 0;
          end else begin
            m_tick[i] = (m_c[i] == m_p[i]);
            m_c[i] = (m_c[i] + 1) % (m_p[i] + 1);
            if (m_tick[i] && os[i]) m_armed[i] = 1'b0;
          end
        end
        m_p[i] = np;
      end
    end
  endtask

  // One clock: update the model, then let outputs settle past the edge.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_inputs();
    en = 1'b0;
    period_wr = 1'b0;
    restart = 4'h0;
  endtask

  task automatic do_reset();
    quiet_inputs();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (tick !== 4'h0) begin
      failures++;
      $display("FAIL reset_tick got=%h exp=%h", tick, 4'h0);
    end
    en = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      cycle();
      checks++;
      if (tick !== ((k % 4 == 0) ? 4'hF : 4'h0)) begin
        failures++;
        $display("FAIL default_period edge=%0d got=%h exp=%h", k, tick,
                 (k % 4 == 0) ? 4'hF : 4'h0);
      end
    end
  endtask

  task automatic test_periods();
    logic [3:0] exp;
    do_reset();
    period_wr = 1'b1;
    period_sel = 2'd1; period_in = 8'd0; cycle();
    period_sel = 2'd2; period_in = 8'd1; cycle();
    period_sel = 2'd3; period_in = 8'd6; cycle();
    period_wr = 1'b0;
    en = 1'b1;
    for (int k = 1; k <= 28; k++) begin
      cycle();
      exp = {(k % 7 == 0), (k % 2 == 0), 1'b0, (k % 4 == 0)};
      checks++;
      if (tick !== exp) begin
        failures++;
        $display("FAIL mixed_periods edge=%0d got=%h exp=%h", k, tick, exp);
      end
    end
  endtask

  task automatic test_shrink();
    do_reset();
    period_wr = 1'b1; period_sel = 2'd0; period_in = 8'd10;
    cycle();
    period_wr = 1'b0;
    en = 1'b1;
    for (int k = 0; k < 7; k++) cycle();
    period_wr = 1'b1; period_in = 8'd4;
    cycle();
    period_wr = 1'b0;
    for (int k = 0; k <= 5; k++) begin
      cycle();
      checks++;
      if (tick[0] !== (k == 5)) begin
        failures++;
        $display("FAIL shrink_period step=%0d got=%b exp=%b", k, tick[0], (k == 5));
      end
      checks++;
      if (tick !== m_tick) begin
        failures++;
        $display("FAIL shrink_model step=%0d got=%h exp=%h", k, tick, m_tick);
      end
    end
  endtask

  task automatic test_enable();
    do_reset();
    en = 1'b1;
    cycle(); cycle();
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      checks++;
      if (tick !== 4'h0) begin
        failures++;
        $display("FAIL en_low step=%0d got=%h exp=%h", k, tick, 4'h0);
      end
    end
    en = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      cycle();
      checks++;
      if (tick !== ((k == 2) ? 4'hF : 4'h0)) begin
        failures++;
        $display("FAIL en_resume edge=%0d got=%h exp=%h", k, tick,
                 (k == 2) ? 4'hF : 4'h0);
      end
    end
  endtask

  task automatic test_restart();
    do_reset();
    en = 1'b1;
    for (int k = 0; k < 3; k++) cycle();
    restart = 4'b0001;
    cycle();
    restart = 4'h0;
    checks++;
    if (tick !== 4'b1110) begin
      failures++;
      $display("FAIL restart_at_wrap got=%h exp=%h", tick, 4'b1110);
    end
    for (int k = 1; k <= 4; k++) begin
      cycle();
      checks++;
      if (tick !== ((k == 4) ? 4'hF : 4'h0)) begin
        failures++;
        $display("FAIL restart_next edge=%0d got=%h exp=%h", k, tick,
                 (k == 4) ? 4'hF : 4'h0);
      end
    end
    cycle(); cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    checks++;
    if (tick !== 4'h0) begin
      failures++;
      $display("FAIL midreset_tick got=%h exp=%h", tick, 4'h0);
    end
    for (int k = 1; k <= 4; k++) begin
      cycle();
      checks++;
      if (tick !== ((k == 4) ? 4'hF : 4'h0)) begin
        failures++;
        $display("FAIL midreset_period edge=%0d got=%h exp=%h", k, tick,
                 (k == 4) ? 4'hF : 4'h0);
      end
    end
  endtask

`ifdef TICK_DIVIDER_ONESHOT_EN
  task automatic test_oneshot();
    do_reset();
    oneshot = 4'b0100;
    en = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      if (k == 12) oneshot = 4'b0000;
      cycle();
      checks++;
      if (tick[2] !== (k == 4)) begin
        failures++;
        $display("FAIL oneshot_single edge=%0d got=%b exp=%b", k, tick[2], (k == 4));
      end
    end
    oneshot = 4'b0100;
    restart = 4'b0100;
    cycle();
    restart = 4'h0;
    for (int k = 1; k <= 8; k++) begin
      cycle();
      checks++;
      if (tick[2] !== (k == 4)) begin
        failures++;
        $display("FAIL oneshot_rearm edge=%0d got=%b exp=%b", k, tick[2], (k == 4));
      end
    end
    oneshot = 4'h0;
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 249) == 0);
      en = ($urandom_range(0, 9) != 0);
      for (int i = 0; i < CH; i++) restart[i] = ($urandom_range(0, 19) == 0);
      period_wr = ($urandom_range(0, 4) == 0);
      period_sel = 2'($urandom_range(0, 3));
      period_in = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255))
                                              : 8'($urandom_range(0, 9));
`ifdef TICK_DIVIDER_ONESHOT_EN
      if ($urandom_range(0, 31) == 0) oneshot = 4'($urandom_range(0, 15));
`endif
      cycle();
      checks++;
      if (tick !== m_tick) begin
        failures++;
        $display("FAIL random_traffic cycle=%0d got=%h exp=%h", n, tick, m_tick);
      end
    end
    reset = 1'b0;
    quiet_inputs();
  endtask

  initial begin
    test_reset();
    test_periods();
    test_shrink();
    test_enable();
    test_restart();
`ifdef TICK_DIVIDER_ONESHOT_EN
    test_oneshot();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tick_divider.md
TICK_DIVIDER -- requirements
Module: tick_divider

Interface
REQ-001 Parameter WIDTH, default 16: per-channel counter and period width in bits.
REQ-002 Parameter CHANNELS, default 4: number of independent tick channels, at least 1.
REQ-003 Parameter DEFAULT_PERIOD, default 2**WIDTH-1: period value loaded into every channel at reset.
REQ-004 clk  input  1: single clock; all state updates on the rising edge.
REQ-005 reset  input  1: synchronous, active-high reset.
REQ-006 en  input  1: global run enable; low freezes all counters.
REQ-007 period_wr  input  1: write strobe for one channel's period register.
REQ-008 period_sel  input  max(1,$clog2(CHANNELS)): channel index for period_wr; out-of-range index ignores the write.
REQ-009 period_in  input  WIDTH: new period value.
REQ-010 restart  input  CHANNELS: per-channel phase restart, level-sampled each cycle.
REQ-011 tick  output  CHANNELS: registered one-cycle pulse per channel.

Function
REQ-012 Each channel i SHALL hold a period register P_i and a counter C_i, both WIDTH bits.
REQ-013 With en=1, restart[i]=0 and P_i>0: if C_i==P_i, tick[i] SHALL go 1 for the next cycle and C_i<=0; else C_i<=C_i+1 and tick[i] SHALL go 0.
REQ-014 Tick spacing SHALL be exactly P_i+1 cycles; the first tick after reset deassertion with en held high SHALL be visible after the (P_i+1)th rising edge.
REQ-015 P_i==0 SHALL halt channel i: C_i held at 0, tick[i]=0.
REQ-016 With en=0, all C_i SHALL hold their values and all tick bits SHALL be 0; P writes and restarts still apply.
REQ-017 restart[i]=1 SHALL set C_i<=0 and tick[i]<=0 that edge, overriding wrap and increment.
REQ-018 period_wr SHALL update P_sel on the edge; the new value governs comparison from the following cycle.
REQ-019 If a period write sets P_i below the current C_i, the next active edge SHALL set C_i<=0 with no tick; no counter SHALL ever pass P_i or wrap through 2**WIDTH.
REQ-020 Simultaneous period_wr and restart on the same channel SHALL both take effect.
REQ-021 Channels SHALL be fully independent; activity on one never alters another's C, P or tick.

Reset
REQ-022 reset=1 SHALL, on the edge: C_i<=0, P_i<=DEFAULT_PERIOD, tick<=0, and one-shot state re-armed, for all channels; reset overrides every other input.
REQ-023 Reset asserted mid-period SHALL discard partial counts; no tick SHALL appear in the cycle after a reset edge.

Configuration
REQ-024 Macro TICK_DIVIDER_ONESHOT_EN defined: add input oneshot (CHANNELS bits); a channel with oneshot[i]=1 SHALL fire one tick, then stop counting (C_i held at 0, tick 0) until restart[i] or reset re-arms it.
REQ-025 Macro TICK_DIVIDER_ONESHOT_EN undefined: oneshot port and its state SHALL be absent; all channels periodic per REQ-013.
REQ-026 Changing oneshot[i] while a channel is stopped SHALL not re-arm it; only restart or reset re-arm.

Verification (WIDTH=8, CHANNELS=4, DEFAULT_PERIOD=3)
REQ-027 Reset then en=1 for 12 cycles -> each tick bit high after edges 4, 8, 12 only, all channels in phase.
REQ-028 Write P_1=0, P_2=1, P_3=6 after reset, en=1 -> tick[1] never, tick[2] every 2 cycles, tick[3] every 7 cycles.
REQ-029 P_0=10, C_0 reaches 7, write P_0=4 -> next edge C_0=0 with no tick; next tick[0] 5 cycles later.
REQ-030 en low for 5 cycles mid-count with C_0=2 -> tick all 0; after en high, tick[0] after 2 more edges (C resumes from 2, period 3).
REQ-031 restart[0] on the cycle C_0==P_0 -> no tick; next tick[0] P_0+1 cycles later; reset mid-period -> tick 0 next cycle, full period restarts.
REQ-032 With TICK_DIVIDER_ONESHOT_EN, oneshot[2]=1 -> single tick[2] after edge 4, silence 20 cycles, restart[2] -> one more tick 4 cycles later.
